// File: rtl/z80_mbox_pkg.sv
// Shared definitions for the Z80 I/O mailbox: register indices, STAT/CTRL
// bit positions, reset values and the I/O port address decoder.
package z80_mbox_pkg;

  // Register indices; the port address is BASE_ADDR + index * ADDR_STRIDE
  localparam int REG_DATA = 0;
  localparam int REG_STAT = 1;
  localparam int REG_CTRL = 2;

  // STAT register bit positions
  localparam int STAT_RX_NOT_EMPTY = 0;
  localparam int STAT_TX_NOT_FULL  = 1;
  localparam int STAT_RX_OVF       = 2;
  localparam int STAT_TX_OVF       = 3;
  localparam int STAT_TX_UDR       = 4;

  // CTRL register bit positions
  localparam int CTRL_FLUSH_RX  = 0;
  localparam int CTRL_FLUSH_TX  = 1;
  localparam int CTRL_CLR_FLAGS = 2;
  localparam int CTRL_IRQ_EN    = 3;

  // Reset values
  localparam logic [7:0] RST_D_OUT       = 8'h00;
  localparam logic [7:0] RST_SPI_TX_DATA = 8'h00;
  localparam logic       RST_SYNC        = 1'b1;
  localparam logic       RST_INT_N       = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_STAT,
    SEL_CTRL
  } port_sel_e;

  // Full 16-bit compare against the three mailbox ports
  function automatic port_sel_e decode_port(input logic [15:0] addr,
                                            input logic [15:0] base,
                                            input logic [15:0] stride);
    port_sel_e sel;
    sel = SEL_NONE;
    if (addr == base + stride * 16'(REG_DATA))      sel = SEL_DATA;
    else if (addr == base + stride * 16'(REG_STAT)) sel = SEL_STAT;
    else if (addr == base + stride * 16'(REG_CTRL)) sel = SEL_CTRL;
    return sel;
  endfunction

endpackage

// File: rtl/mbox_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers, synchronous flush and a
// combinational head output. A pop on empty is ignored; a push on full
// succeeds only when a pop happens in the same cycle.
module mbox_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state; flush overrides any same-cycle push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/z80_io_mailbox_fifo.sv
// Z80 I/O mailbox with TX/RX FIFOs between the Z80 bus and an SPI byte engine.
// Ports: DATA (FIFO access), STAT (flags), CTRL (flush/clear/irq_en).
// Optional macro Z80_MBOX_IRQ_EN enables the registered /INT output;
// without it /INT is tied inactive while irq_en still reads back.
module z80_io_mailbox_fifo
  import z80_mbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'd12345,
  parameter int          ADDR_STRIDE = 2,
  parameter int          DEPTH       = 8,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_a,
  input  logic [7:0]  z80_d_in,
  output logic [7:0]  z80_d_out,
  output logic        z80_d_drive,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_iorq_n,
  input  logic        z80_m1_n,
  output logic        z80_int_n,
  input  logic        spi_rx_valid,
  input  logic [7:0]  spi_rx_data,
  input  logic        spi_tx_req,
  output logic [7:0]  spi_tx_data,
  output logic        spi_tx_valid
);

  localparam int PIN_WR = 0, PIN_RD = 1, PIN_IORQ = 2, PIN_M1 = 3;

  logic [3:0] sync1_q, sync2_q;
  logic       io_wr, io_rd, io_wr_prev_q, io_rd_prev_q;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       rd_data_sel_q, rd_data_sel_d;
  logic       wr_commit, rd_done, ctrl_wr;
  port_sel_e  bus_sel;

  logic       irq_en_q, irq_en_d;
  logic       tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, tx_udr_q, tx_udr_d;
  logic       clr_flags, tx_ovf_set, rx_ovf_set, tx_udr_set;
  logic       spi_tx_valid_q;
  logic [7:0] spi_tx_data_q, spi_tx_data_d;

  logic       tx_push, tx_flush, tx_empty, tx_full;
  logic       rx_pop, rx_flush, rx_empty, rx_full;
  logic [7:0] tx_dout, rx_dout, stat_byte, ctrl_byte;

  assign bus_sel = decode_port(z80_a, BASE_ADDR, 16'(ADDR_STRIDE));

  // Two-flop synchronisers for the bus strobes, idle (high) out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {4{RST_SYNC}};
      sync2_q <= {4{RST_SYNC}};
    end else begin
      sync1_q <= {z80_m1_n, z80_iorq_n, z80_rd_n, z80_wr_n};
      sync2_q <= sync1_q;
    end
  end

  assign io_wr = ~sync2_q[PIN_IORQ] & ~sync2_q[PIN_WR] & sync2_q[PIN_M1];
  assign io_rd = ~sync2_q[PIN_IORQ] & ~sync2_q[PIN_RD] & sync2_q[PIN_M1];

  // Edge detection is armed only once the synchronised bus has been seen
  // idle after reset, so a cycle caught in flight by reset is discarded.
  assign fill_d        = {fill_q[0], 1'b1};
  assign armed_d       = armed_q | (fill_q[1] & ~io_wr & ~io_rd);
  assign rd_data_sel_d = io_rd ? (bus_sel == SEL_DATA) : rd_data_sel_q;
  assign wr_commit     = armed_q & io_wr & ~io_wr_prev_q;
  assign rd_done       = armed_q & ~io_rd & io_rd_prev_q;
  assign ctrl_wr       = wr_commit & (bus_sel == SEL_CTRL);

  assign tx_push  = wr_commit & (bus_sel == SEL_DATA);
  assign tx_flush = ctrl_wr & z80_d_in[CTRL_FLUSH_TX];
  assign rx_flush = ctrl_wr & z80_d_in[CTRL_FLUSH_RX];
  assign rx_pop   = rd_done & rd_data_sel_q;

  mbox_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (z80_d_in),
    .pop   (spi_tx_req),
    .flush (tx_flush),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full)
  );

  mbox_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (spi_rx_valid),
    .din   (spi_rx_data),
    .pop   (rx_pop),
    .flush (rx_flush),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // Sticky flags (set beats clear), irq enable and the SPI TX byte
  always_comb begin
    clr_flags     = ctrl_wr & z80_d_in[CTRL_CLR_FLAGS];
    tx_ovf_set    = tx_push & tx_full & ~spi_tx_req;
    rx_ovf_set    = spi_rx_valid & rx_full & ~rx_pop;
    tx_udr_set    = spi_tx_req & tx_empty;
    tx_ovf_d      = tx_ovf_set | (tx_ovf_q & ~clr_flags);
    rx_ovf_d      = rx_ovf_set | (rx_ovf_q & ~clr_flags);
    tx_udr_d      = tx_udr_set | (tx_udr_q & ~clr_flags);
    irq_en_d      = ctrl_wr ? z80_d_in[CTRL_IRQ_EN] : irq_en_q;
    spi_tx_data_d = spi_tx_data_q;
    if (spi_tx_req) spi_tx_data_d = tx_empty ? FILL_BYTE : tx_dout;
  end

  // Control and status state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_wr_prev_q   <= 1'b0;
      io_rd_prev_q   <= 1'b0;
      fill_q         <= 2'b00;
      armed_q        <= 1'b0;
      rd_data_sel_q  <= 1'b0;
      irq_en_q       <= 1'b0;
      tx_ovf_q       <= 1'b0;
      rx_ovf_q       <= 1'b0;
      tx_udr_q       <= 1'b0;
      spi_tx_valid_q <= 1'b0;
      spi_tx_data_q  <= RST_SPI_TX_DATA;
    end else begin
      io_wr_prev_q   <= io_wr;
      io_rd_prev_q   <= io_rd;
      fill_q         <= fill_d;
      armed_q        <= armed_d;
      rd_data_sel_q  <= rd_data_sel_d;
      irq_en_q       <= irq_en_d;
      tx_ovf_q       <= tx_ovf_d;
      rx_ovf_q       <= rx_ovf_d;
      tx_udr_q       <= tx_udr_d;
      spi_tx_valid_q <= spi_tx_req;
      spi_tx_data_q  <= spi_tx_data_d;
    end
  end

  assign spi_tx_valid = spi_tx_valid_q;
  assign spi_tx_data  = spi_tx_data_q;

  // Read path from raw pins so data is valid well before the Z80 samples it
  always_comb begin
    stat_byte                    = 8'h00;
    stat_byte[STAT_RX_NOT_EMPTY] = ~rx_empty;
    stat_byte[STAT_TX_NOT_FULL]  = ~tx_full;
    stat_byte[STAT_RX_OVF]       = rx_ovf_q;
    stat_byte[STAT_TX_OVF]       = tx_ovf_q;
    stat_byte[STAT_TX_UDR]       = tx_udr_q;
    ctrl_byte                    = 8'h00;
    ctrl_byte[CTRL_IRQ_EN]       = irq_en_q;
    z80_d_drive = ~rst & ~z80_iorq_n & ~z80_rd_n & z80_m1_n & (bus_sel != SEL_NONE);
    z80_d_out   = RST_D_OUT;
    if (z80_d_drive) begin
      case (bus_sel)
        SEL_DATA: z80_d_out = rx_empty ? FILL_BYTE : rx_dout;
        SEL_STAT: z80_d_out = stat_byte;
        SEL_CTRL: z80_d_out = ctrl_byte;
        default:  z80_d_out = RST_D_OUT;
      endcase
    end
  end

`ifdef Z80_MBOX_IRQ_EN
  logic int_n_q, int_n_d;

  assign int_n_d = ~(irq_en_q & (~rx_empty | tx_ovf_q | rx_ovf_q | tx_udr_q));

  // Registered interrupt request, active low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_n_q <= RST_INT_N;
    else     int_n_q <= int_n_d;
  end

  assign z80_int_n = int_n_q;
`else
  assign z80_int_n = RST_INT_N;
`endif

endmodule
